// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: PS/2 scan codes, joystick bit positions and coin FSM states shared by the input mapper.
package arcade_input_pkg;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_CTRL  = 9'h014;
    localparam logic [8:0] KEY_F1    = 9'h005;
    localparam logic [8:0] KEY_F2    = 9'h006;

    localparam int JOY_R  = 0;
    localparam int JOY_L  = 1;
    localparam int JOY_D  = 2;
    localparam int JOY_U  = 3;
    localparam int JOY_FIRE = 4;
    localparam int JOY_S1 = 5;
    localparam int JOY_S2 = 6;

    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;
endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// coin_pulser: turns start-button edges into fixed-length coin pulses separated by a mandatory gap.
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int COIN_CYCLES = 2_400_000,
    parameter int GAP_CYCLES  = 2_400_000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic trig,
    output logic coin,
    output logic busy
);
    localparam int MAX_CYCLES = COIN_CYCLES > GAP_CYCLES ? COIN_CYCLES : GAP_CYCLES;
    localparam int CW = MAX_CYCLES > 1 ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    coin_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic pending, pending_n, done, take;

    assign done = cnt == '0;
    // a pending request is consumed either from IDLE or at the very end of the gap
    assign take = pending && (state == IDLE || (state == GAP && done));
    assign pending_n = (pending && !take) || (trig && state != IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= pending_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:  if (trig || pending) begin state_n = PULSE; cnt_n = COIN_LOAD; end
            PULSE: if (done) begin state_n = GAP; cnt_n = GAP_LOAD; end else cnt_n = cnt - 1'b1;
            GAP:   if (done) begin state_n = pending ? PULSE : IDLE; cnt_n = COIN_LOAD; end else cnt_n = cnt - 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        coin = state == PULSE;
        busy = state != IDLE;
    end
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges PS/2 keys and joystick into active-low pacman input words,
// with orientation remap and start-to-coin pulse conversion.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int COIN_CYCLES = 2_400_000,
    parameter int GAP_CYCLES  = 2_400_000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rotate,
    output logic [7:0]  in0_reg,
    output logic [7:0]  in1_reg,
    output logic        coin_busy
);
    logic prev, armed, ev, s_prev, trig, coin, unused_joy;
    logic k_up, k_down, k_left, k_right, k_fire, k_s1, k_s2;
    logic up, down, left, right, fire, s1, s2;
    logic [8:0] code;

    assign code = ps2_key[8:0];
    assign ev = armed && (ps2_key[10] != prev);
    assign unused_joy = ^joy[15:7];

    // Horz rotates the panel a quarter turn: physical left drives up, up drives right
    always_comb begin
        up    = rotate ? (k_left  | joy[JOY_L]) : (k_up    | joy[JOY_U]);
        down  = rotate ? (k_right | joy[JOY_R]) : (k_down  | joy[JOY_D]);
        left  = rotate ? (k_down  | joy[JOY_D]) : (k_left  | joy[JOY_L]);
        right = rotate ? (k_up    | joy[JOY_U]) : (k_right | joy[JOY_R]);
        fire  = k_fire | joy[JOY_FIRE];
        s1    = k_s1 | joy[JOY_S1];
        s2    = k_s2 | joy[JOY_S2];
    end

    assign trig = (!in1_reg[5] || !in1_reg[6]) && !s_prev;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev    <= 1'b0;
            armed   <= 1'b0;
            s_prev  <= 1'b0;
            k_up    <= 1'b0;
            k_down  <= 1'b0;
            k_left  <= 1'b0;
            k_right <= 1'b0;
            k_fire  <= 1'b0;
            k_s1    <= 1'b0;
            k_s2    <= 1'b0;
            in0_reg <= 8'hFF;
            in1_reg <= 8'hFF;
        end else begin
            prev    <= ps2_key[10];
            armed   <= 1'b1;
            s_prev  <= !in1_reg[5] || !in1_reg[6];
            if (ev) begin
                if (code[7:0] == KEY_UP) k_up <= ps2_key[9];
                if (code[7:0] == KEY_DOWN) k_down <= ps2_key[9];
                if (code[7:0] == KEY_LEFT) k_left <= ps2_key[9];
                if (code[7:0] == KEY_RIGHT) k_right <= ps2_key[9];
                if (code == KEY_SPACE || code == KEY_CTRL) k_fire <= ps2_key[9];
                if (code == KEY_F1) k_s1 <= ps2_key[9];
                if (code == KEY_F2) k_s2 <= ps2_key[9];
            end
            in0_reg <= ~{2'b00, coin, 1'b0, down, right, left, up};
            in1_reg <= ~{1'b0, s2, s1, fire, 4'b0000};
        end
    end

    coin_pulser #(
        .COIN_CYCLES(COIN_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_coin (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .trig   (trig),
        .coin   (coin),
        .busy   (coin_busy)
    );
endmodule
